// File: rtl/ram2e_efb_arbiter.sv
// Two-requester arbiter for the MachXO2 EFB Wishbone slave port, with frame lock.
// Optional WAIT_ACK abort is enabled by defining RAM2E_EFB_TIMEOUT_EN.
module ram2e_efb_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       C14M,
    input  logic       nRST,
    input  logic       r0_req,
    input  logic       r0_we,
    input  logic [7:0] r0_adr,
    input  logic [7:0] r0_dat,
    input  logic       r0_lock,
    output logic       r0_ack,
    output logic       r0_err,
    input  logic       r1_req,
    input  logic       r1_we,
    input  logic [7:0] r1_adr,
    input  logic [7:0] r1_dat,
    input  logic       r1_lock,
    output logic       r1_ack,
    output logic       r1_err,
    output logic [7:0] rd_dat,
    output logic       wb_cyc_stb,
    output logic       wb_we,
    output logic [7:0] wb_adr,
    output logic [7:0] wb_dati,
    input  logic [7:0] wb_dato,
    input  logic       wb_ack,
    output logic       owner,
    output logic       locked,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_cyc_stb, w_cyc_stb_nxt;
    logic       r_we, w_we_nxt;
    logic [7:0] r_adr, w_adr_nxt;
    logic [7:0] r_dati, w_dati_nxt;
    logic [7:0] r_rd_dat, w_rd_dat_nxt;
    logic       r_ack0, w_ack0_nxt;
    logic       r_ack1, w_ack1_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_locked, w_locked_nxt;
    logic       r_busy;
    logic       w_owner_lock, w_owner_req, w_hold;
    logic       w_grant, w_sel;

`ifdef RAM2E_EFB_TIMEOUT_EN
    localparam logic [TW-1:0] C_CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] C_CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] C_CNT_MAX  = TIMEOUT[TW-1:0];
    logic [TW-1:0] r_cnt, w_cnt_nxt;
    logic          r_err0, w_err0_nxt;
    logic          r_err1, w_err1_nxt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT[TW-1:0]};
`endif

    assign w_owner_lock = r_owner ? r1_lock : r0_lock;
    assign w_owner_req  = r_owner ? r1_req  : r0_req;
    // The held grant survives only while the owner keeps its lock asserted.
    assign w_hold       = r_locked & w_owner_lock;

    // State register.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration and datapath next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_stb_nxt = r_cyc_stb;
        w_we_nxt      = r_we;
        w_adr_nxt     = r_adr;
        w_dati_nxt    = r_dati;
        w_rd_dat_nxt  = r_rd_dat;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_owner_nxt   = r_owner;
        w_locked_nxt  = r_locked;
        w_grant       = 1'b0;
        w_sel         = 1'b0;
`ifdef RAM2E_EFB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_err0_nxt    = 1'b0;
        w_err1_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_locked_nxt = w_hold;
                if (w_hold) begin
                    w_grant = w_owner_req;
                    w_sel   = r_owner;
                end else if (r0_req) begin
                    w_grant = 1'b1;
                    w_sel   = 1'b0;
                end else begin
                    w_grant = r1_req;
                    w_sel   = 1'b1;
                end
                if (w_grant) begin
                    w_we_nxt    = w_sel ? r1_we  : r0_we;
                    w_adr_nxt   = w_sel ? r1_adr : r0_adr;
                    w_dati_nxt  = w_sel ? r1_dat : r0_dat;
                    w_owner_nxt = w_sel;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_cyc_stb_nxt = 1'b1;
`ifdef RAM2E_EFB_TIMEOUT_EN
                w_cnt_nxt     = C_CNT_ZERO;
`endif
                w_state_nxt   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (wb_ack) begin
                    w_cyc_stb_nxt = 1'b0;
                    w_rd_dat_nxt  = wb_dato;
                    w_ack0_nxt    = ~r_owner;
                    w_ack1_nxt    = r_owner;
                    w_locked_nxt  = w_owner_lock;
                    w_state_nxt   = S_RELEASE;
`ifdef RAM2E_EFB_TIMEOUT_EN
                end else if (r_cnt == C_CNT_MAX) begin
                    // Abandon the whole frame, not just this access.
                    w_cyc_stb_nxt = 1'b0;
                    w_rd_dat_nxt  = 8'hFF;
                    w_ack0_nxt    = ~r_owner;
                    w_ack1_nxt    = r_owner;
                    w_err0_nxt    = ~r_owner;
                    w_err1_nxt    = r_owner;
                    w_locked_nxt  = 1'b0;
                    w_state_nxt   = S_RELEASE;
                end else begin
                    w_cnt_nxt     = r_cnt + C_CNT_ONE;
                    w_state_nxt   = S_WAIT_ACK;
`else
                end else begin
                    w_state_nxt   = S_WAIT_ACK;
`endif
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered bus, handshake and status outputs.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            r_cyc_stb <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 8'h00;
            r_dati    <= 8'h00;
            r_rd_dat  <= 8'h00;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_owner   <= 1'b0;
            r_locked  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cyc_stb <= w_cyc_stb_nxt;
            r_we      <= w_we_nxt;
            r_adr     <= w_adr_nxt;
            r_dati    <= w_dati_nxt;
            r_rd_dat  <= w_rd_dat_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_owner   <= w_owner_nxt;
            r_locked  <= w_locked_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef RAM2E_EFB_TIMEOUT_EN
    // Timeout counter and error flags.
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            r_cnt  <= C_CNT_ZERO;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_err0 <= w_err0_nxt;
            r_err1 <= w_err1_nxt;
        end
    end

    assign r0_err = r_err0;
    assign r1_err = r_err1;
`else
    assign r0_err = 1'b0;
    assign r1_err = 1'b0;
`endif

    assign wb_cyc_stb = r_cyc_stb;
    assign wb_we      = r_we;
    assign wb_adr     = r_adr;
    assign wb_dati    = r_dati;
    assign rd_dat     = r_rd_dat;
    assign r0_ack     = r_ack0;
    assign r1_ack     = r_ack1;
    assign owner      = r_owner;
    assign locked     = r_locked;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ram2e_efb_arbiter.sv
// Directed bench for ram2e_efb_arbiter with a 1-cycle-latency EFB responder model.
module tb_ram2e_efb_arbiter;
    localparam int TO = 8;

    logic       C14M = 1'b0;
    logic       nRST;
    logic       r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [7:0] r0_adr, r0_dat, r1_adr, r1_dat;
    logic       r0_ack, r0_err, r1_ack, r1_err;
    logic [7:0] rd_dat, wb_adr, wb_dati;
    logic       wb_cyc_stb, wb_we, owner, locked, busy;
    logic [7:0] efb_dato;
    logic       efb_ack = 1'b0;
    logic       efb_en;

    int n_cmp = 0;
    int n_bad = 0;

    int stb_cnt = 0, a0_cnt = 0, a1_cnt = 0, both_cnt = 0, errbad_cnt = 0;
    logic [8:0] log_q [0:15];
    int log_n = 0;

    ram2e_efb_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
        .C14M(C14M), .nRST(nRST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_dat(r0_dat), .r0_lock(r0_lock),
        .r0_ack(r0_ack), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_dat(r1_dat), .r1_lock(r1_lock),
        .r1_ack(r1_ack), .r1_err(r1_err),
        .rd_dat(rd_dat), .wb_cyc_stb(wb_cyc_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dati(wb_dati), .wb_dato(efb_dato), .wb_ack(efb_ack),
        .owner(owner), .locked(locked), .busy(busy)
    );

    always #5 C14M = ~C14M;

    // EFB model: acknowledges one cycle after it first sees the strobe.
    always @(posedge C14M) efb_ack <= efb_en & wb_cyc_stb & ~efb_ack;

    // Bus monitor, sampled on the falling edge.
    always @(negedge C14M) begin
        stb_cnt <= stb_cnt + (wb_cyc_stb ? 1 : 0);
        a0_cnt  <= a0_cnt + (r0_ack ? 1 : 0);
        a1_cnt  <= a1_cnt + (r1_ack ? 1 : 0);
        if (r0_ack && r1_ack) both_cnt <= both_cnt + 1;
        if ((!r0_ack && r0_err) || (!r1_ack && r1_err)) errbad_cnt <= errbad_cnt + 1;
        if (r0_ack || r1_ack) begin
            log_q[log_n[3:0]] <= {r1_ack, wb_adr};
            log_n <= log_n + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge C14M);
            #1;
        end
    endtask

    task automatic wait_ack(input int who, input int max_cyc, input string tag);
        int  k = 0;
        bit  seen = 1'b0;
        while (!seen && k < max_cyc) begin
            tick();
            k++;
            if ((who == 0 && r0_ack) || (who == 1 && r1_ack)) seen = 1'b1;
        end
        check_val(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_stb(input int max_cyc, input string tag);
        int k = 0;
        while (!wb_cyc_stb && k < max_cyc) begin
            tick();
            k++;
        end
        check_val(tag, {31'd0, wb_cyc_stb}, 32'd1);
    endtask

    int s_stb, s_a0, s_a1, s_log;

    initial begin
        nRST = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_adr = 8'h00; r0_dat = 8'h00; r0_lock = 1'b0;
        r1_req = 1'b0; r1_we = 1'b0; r1_adr = 8'h00; r1_dat = 8'h00; r1_lock = 1'b0;
        efb_en = 1'b1; efb_dato = 8'h00;
        tick(3);
        check_val("rst_outs", {13'd0, r0_ack, r0_err, r1_ack, r1_err, rd_dat, wb_cyc_stb,
                               wb_we, wb_adr, owner, locked, busy}, 32'd0);
        check_val("rst_dati", {24'd0, wb_dati}, 32'd0);
        nRST = 1'b1;
        tick(2);
        check_val("idle_busy", {31'd0, busy}, 32'd0);

        // Single r0 write, EFB acks one cycle after strobe.
        s_stb = stb_cnt; s_a0 = a0_cnt; s_a1 = a1_cnt;
        efb_dato = 8'h3C;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 8'h70; r0_dat = 8'h80;
        wait_ack(0, 20, "t1_ack0");
        r0_req = 1'b0;
        check_val("t1_adr",  {24'd0, wb_adr},  32'h70);
        check_val("t1_dati", {24'd0, wb_dati}, 32'h80);
        check_val("t1_we",   {31'd0, wb_we},   32'd1);
        check_val("t1_own",  {31'd0, owner},   32'd0);
        check_val("t1_rd",   {24'd0, rd_dat},  32'h3C);
        tick(2);
        check_val("t1_stb2", stb_cnt - s_stb, 32'd2);
        check_val("t1_a0",   a0_cnt - s_a0,   32'd1);
        check_val("t1_a1",   a1_cnt - s_a1,   32'd0);
        check_val("t1_busy", {31'd0, busy},   32'd0);

        // Simultaneous requests: r0 first, then r1 read.
        s_a1 = a1_cnt;
        efb_dato = 8'h5A;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 8'h20; r0_dat = 8'h11;
        r1_req = 1'b1; r1_we = 1'b0; r1_adr = 8'h73; r1_dat = 8'h00;
        wait_ack(0, 20, "t2_ack0");
        r0_req = 1'b0;
        check_val("t2_a1_early", a1_cnt - s_a1, 32'd0);
        check_val("t2_adr0", {24'd0, wb_adr}, 32'h20);
        wait_ack(1, 20, "t2_ack1");
        r1_req = 1'b0;
        check_val("t2_rd",  {24'd0, rd_dat}, 32'h5A);
        check_val("t2_own", {31'd0, owner},  32'd1);
        check_val("t2_adr1", {24'd0, wb_adr}, 32'h73);
        check_val("t2_we1", {31'd0, wb_we}, 32'd0);
        tick(2);

        // r1 locked frame of three writes while r0 is waiting.
        s_a0 = a0_cnt; s_log = log_n;
        r1_req = 1'b1; r1_lock = 1'b1; r1_we = 1'b1; r1_adr = 8'h70; r1_dat = 8'h80;
        tick();
        check_val("t3_granted", {30'd0, owner, busy}, 32'd3);
        r0_req = 1'b1; r0_we = 1'b0; r0_adr = 8'h10; r0_lock = 1'b0;
        wait_ack(1, 20, "t3_ack1a");
        check_val("t3_lock_a", {31'd0, locked}, 32'd1);
        r1_adr = 8'h71; r1_dat = 8'hB4;
        wait_ack(1, 20, "t3_ack1b");
        check_val("t3_dati_b", {24'd0, wb_dati}, 32'hB4);
        r1_adr = 8'h70; r1_dat = 8'h00;
        wait_ack(1, 20, "t3_ack1c");
        check_val("t3_a0_none", a0_cnt - s_a0, 32'd0);
        r1_req = 1'b0; r1_lock = 1'b0;
        wait_ack(0, 20, "t3_ack0");
        r0_req = 1'b0;
        check_val("t3_log0", {23'd0, log_q[s_log]},     {23'd0, 9'h170});
        check_val("t3_log1", {23'd0, log_q[s_log + 1]}, {23'd0, 9'h171});
        check_val("t3_log2", {23'd0, log_q[s_log + 2]}, {23'd0, 9'h170});
        check_val("t3_log3", {23'd0, log_q[s_log + 3]}, {23'd0, 9'h010});
        check_val("t3_unlock", {31'd0, locked}, 32'd0);
        tick(2);

`ifdef RAM2E_EFB_TIMEOUT_EN
        // EFB never acks: abort after the counter reaches TIMEOUT.
        efb_en = 1'b0;
        s_stb = stb_cnt;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 8'h30; r0_dat = 8'h01; r0_lock = 1'b1;
        wait_ack(0, 40, "t4_ack0");
        r0_req = 1'b0; r0_lock = 1'b0;
        check_val("t4_err",  {31'd0, r0_err}, 32'd1);
        check_val("t4_rd",   {24'd0, rd_dat}, 32'hFF);
        check_val("t4_lock", {31'd0, locked}, 32'd0);
        check_val("t4_stb",  {31'd0, wb_cyc_stb}, 32'd0);
        // Strobe is high for counter values 0..TIMEOUT inclusive.
        check_val("t4_stbn", stb_cnt - s_stb, TO + 1);
        efb_en = 1'b1;
        tick(2);
`else
        // Without the timeout the cycle stays open until the EFB acks.
        efb_en = 1'b0;
        s_a0 = a0_cnt;
        efb_dato = 8'h99;
        r0_req = 1'b1; r0_we = 1'b0; r0_adr = 8'h30; r0_lock = 1'b0;
        tick(300);
        check_val("t4_stb_held", {30'd0, wb_cyc_stb, busy}, 32'd3);
        check_val("t4_no_ack", a0_cnt - s_a0, 32'd0);
        efb_en = 1'b1;
        wait_ack(0, 10, "t4_ack0");
        r0_req = 1'b0;
        check_val("t4_err0", {31'd0, r0_err}, 32'd0);
        check_val("t4_rd",   {24'd0, rd_dat}, 32'h99);
        tick(2);
`endif

        // Reset asserted while waiting for ack.
        efb_en = 1'b0;
        s_a0 = a0_cnt; s_a1 = a1_cnt;
        r0_req = 1'b1; r0_we = 1'b1; r0_adr = 8'h55; r0_dat = 8'hAA;
        wait_stb(10, "t5_stb_up");
        nRST = 1'b0;
        #1;
        check_val("t5_stb_drop", {31'd0, wb_cyc_stb}, 32'd0);
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        r0_req = 1'b0;
        tick(3);
        check_val("t5_no_ack", (a0_cnt - s_a0) + (a1_cnt - s_a1), 32'd0);
        nRST = 1'b1;
        tick();
        efb_en = 1'b1; efb_dato = 8'hC3;
        r1_req = 1'b1; r1_we = 1'b0; r1_adr = 8'h44;
        wait_ack(1, 20, "t5_ack1");
        r1_req = 1'b0;
        check_val("t5_rd",  {24'd0, rd_dat}, 32'hC3);
        check_val("t5_own", {31'd0, owner},  32'd1);
        tick(3);

        check_val("excl_acks", both_cnt, 32'd0);
        check_val("err_wo_ack", errbad_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
